cpu_ctrl_fsm: RTL and testbench
===============================

// Module: cpu_ctrl_fsm
// PURPOSE
//  Multi-cycle control unit sequencing the RV32I datapath around the ALU: fetch, decode, execute, mem, writeback.
//  Latches the instruction, drives ALU opcode/funct/operand-select, register-file write enable, PC update and
//  instruction/data memory req/ack handshakes. Sits between the memories and the datapath in the CPU top.
// PARAMETERS
//  XLEN        32  datapath width (instruction register and instr_in are XLEN bits wide)
//  PERF_CNT_W  32  width of performance counters (CPU_CTRL_PERF_EN only)
// PORTS
//  clk_in         in   1   clock, rising edge
//  rst_n_in       in   1   asynchronous active-low reset
//  imem_req_out   out  1   instruction fetch request, held until imem_ack_in
//  imem_ack_in    in   1   instr_in valid this cycle
//  instr_in       in   32  fetched instruction
//  dmem_req_out   out  1   data access request, held until dmem_ack_in
//  dmem_we_out    out  1   1 = store, 0 = load; valid while dmem_req_out
//  dmem_ack_in    in   1   data access complete (load data valid this cycle)
//  branch_taken_in in  1   branch compare result from datapath, sampled in EXEC
//  opcode_out     out  7   ALU opcode; funct3_out out 3; funct7_out out 7
//  alu_src_imm_out out 1   1 = ALU operand B is the immediate
//  rf_we_out      out  1   register-file write strobe, one cycle
//  wb_sel_out     out  1   0 = ALU result, 1 = load data
//  pc_en_out      out  1   PC update strobe, one cycle
//  pc_sel_out     out  1   0 = PC+4, 1 = branch target; valid with pc_en_out
//  trap_out       out  1   illegal instruction, sticky
//  state_out      out  3   current state (debug)
// BEHAVIOUR
//  - States: RESET(0) FETCH(1) DECODE(2) EXEC(3) MEM(4) WB(5) TRAP(6). Moore outputs from state + IR.
//  - Reset: state=RESET, IR=0, every output 0. First edge after release: RESET->FETCH.
//  - FETCH: imem_req_out=1 until imem_ack_in; ack accepted even in the first FETCH cycle. On ack: IR<=instr_in, ->DECODE.
//  - DECODE (1 cycle): classify IR[6:0]: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011;
//    any other ->TRAP, else ->EXEC.
//  - Outputs from DECODE through WB stay constant from IR: R/I pass IR opcode/funct3; funct7_out=IR[31:25] for R and
//    for I with funct3 001/101, else 0. LOAD/STORE force opcode_out=0010011, funct3_out=000, funct7_out=0 (address add).
//    BRANCH passes IR fields. alu_src_imm_out=1 for I/LOAD/STORE.
//  - EXEC: R/I ->WB; LOAD/STORE ->MEM; BRANCH: pc_en_out=1, pc_sel_out=branch_taken_in, ->FETCH.
//  - MEM: dmem_req_out=1, dmem_we_out=(STORE) until dmem_ack_in. On ack: STORE -> pc_en_out=1, ->FETCH;
//    LOAD ->WB. No req outside MEM.
//  - WB: rf_we_out=1 unless IR[11:7]==0 (x0 writes suppressed); wb_sel_out=LOAD; pc_en_out=1, pc_sel_out=0; ->FETCH.
//  - TRAP: trap_out=1, all strobes/reqs 0; leaves only via reset.
//  - Acks outside their request state are ignored. Requests never drop before ack.
//  - Reset mid-handshake: reqs drop immediately (async), no strobe emitted.
//  - Latency, zero-wait memory: R/I 4 cycles, LOAD 5, STORE 4, BRANCH 3 (FETCH to next FETCH).
// CONFIGURATION
//  CPU_CTRL_PERF_EN defined: adds outputs cycle_cnt_out[PERF_CNT_W-1:0] (+1 every cycle out of RESET)
//   and instret_cnt_out (+1 on each pc_en_out); both wrap to 0, both reset 0, freeze in TRAP.
//  Undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  cpu_ctrl_pkg: opcode localparams, state encoding, wb_sel encoding, instruction-class enum.
//  Sub-module cpu_ctrl_decode: combinational IR -> class/legal/ALU-field mapping; FSM + IR + counters in top.
// TESTING
//  - Reset then ADDI x1,x0,5 (0x00500093), ack in first FETCH -> states 1,2,3,5,1; rf_we_out=1 in WB, wb_sel_out=0.
//  - LW x2,4(x1) with dmem_ack_in delayed 3 cycles -> dmem_req_out held 4 cycles, dmem_we_out=0, opcode_out=0010011/000, rf_we 1 cycle.
//  - SW x2,8(x1) -> dmem_we_out=1 in MEM, rf_we_out never 1, pc_en_out=1 on ack cycle.
//  - BEQ with branch_taken_in=1 -> pc_en_out=1, pc_sel_out=1 in EXEC; repeat with 0 -> pc_sel_out=0.
//  - ADD x0,x1,x2 -> no rf_we_out; instr 0xFFFFFFFF -> TRAP, trap_out sticky 20 cycles, no reqs.
//  - rst_n_in low while imem_req_out high -> req drops same cycle; restarts RESET->FETCH; stray acks ignored.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle control unit: opcodes, state
// encoding, writeback select encoding and instruction classes.
package cpu_ctrl_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic WB_SEL_ALU = 1'b0;
    localparam logic WB_SEL_MEM = 1'b1;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        CLS_ILLEGAL = 3'd0,
        CLS_R       = 3'd1,
        CLS_I       = 3'd2,
        CLS_LOAD    = 3'd3,
        CLS_STORE   = 3'd4,
        CLS_BRANCH  = 3'd5
    } instr_class_e;

    // Shift-immediate forms carry funct7 (arithmetic/logical select).
    function automatic logic is_shift_funct3(input logic [2:0] f3);
        return (f3 == 3'b001) || (f3 == 3'b101);
    endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational decode of the latched instruction into class, legality and
// the ALU field values held constant from DECODE through WB.
module cpu_ctrl_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] ir,
    output instr_class_e    instr_class,
    output logic            legal,
    output logic [6:0]      alu_opcode,
    output logic [2:0]      alu_funct3,
    output logic [6:0]      alu_funct7,
    output logic            alu_src_imm,
    output logic            rd_is_zero
);

    logic unused_ir_bits;
    assign unused_ir_bits = ^ir[24:15];

    assign rd_is_zero = (ir[11:7] == 5'd0);

    always_comb begin
        instr_class = CLS_ILLEGAL;
        legal       = 1'b0;
        alu_opcode  = 7'd0;
        alu_funct3  = 3'd0;
        alu_funct7  = 7'd0;
        alu_src_imm = 1'b0;
        case (ir[6:0])
            OPC_R: begin
                instr_class = CLS_R;
                legal       = 1'b1;
                alu_opcode  = ir[6:0];
                alu_funct3  = ir[14:12];
                alu_funct7  = ir[31:25];
            end
            OPC_I: begin
                instr_class = CLS_I;
                legal       = 1'b1;
                alu_opcode  = ir[6:0];
                alu_funct3  = ir[14:12];
                alu_funct7  = is_shift_funct3(ir[14:12]) ? ir[31:25] : 7'd0;
                alu_src_imm = 1'b1;
            end
            // Loads and stores borrow the ALU as an address adder.
            OPC_LOAD, OPC_STORE: begin
                instr_class = (ir[6:0] == OPC_LOAD) ? CLS_LOAD : CLS_STORE;
                legal       = 1'b1;
                alu_opcode  = OPC_I;
                alu_src_imm = 1'b1;
            end
            OPC_BRANCH: begin
                instr_class = CLS_BRANCH;
                legal       = 1'b1;
                alu_opcode  = ir[6:0];
                alu_funct3  = ir[14:12];
                alu_funct7  = ir[31:25];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle RV32I control FSM: fetch, decode, execute, mem, writeback.
// Define CPU_CTRL_PERF_EN to add cycle and retired-instruction counters.
module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int XLEN = 32
`ifdef CPU_CTRL_PERF_EN
    ,
    parameter int PERF_CNT_W = 32
`endif
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    output logic            imem_req_out,
    input  logic            imem_ack_in,
    input  logic [XLEN-1:0] instr_in,
    output logic            dmem_req_out,
    output logic            dmem_we_out,
    input  logic            dmem_ack_in,
    input  logic            branch_taken_in,
    output logic [6:0]      opcode_out,
    output logic [2:0]      funct3_out,
    output logic [6:0]      funct7_out,
    output logic            alu_src_imm_out,
    output logic            rf_we_out,
    output logic            wb_sel_out,
    output logic            pc_en_out,
    output logic            pc_sel_out,
    output logic            trap_out,
    output logic [2:0]      state_out
`ifdef CPU_CTRL_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] cycle_cnt_out,
    output logic [PERF_CNT_W-1:0] instret_cnt_out
`endif
);

    state_e          state_reg, state_next;
    logic [XLEN-1:0] ir_reg, ir_next;

    instr_class_e    dec_class;
    logic            dec_legal;
    logic [6:0]      dec_opcode;
    logic [2:0]      dec_funct3;
    logic [6:0]      dec_funct7;
    logic            dec_src_imm;
    logic            dec_rd_zero;

    cpu_ctrl_decode #(.XLEN(XLEN)) u_decode (
        .ir          (ir_reg),
        .instr_class (dec_class),
        .legal       (dec_legal),
        .alu_opcode  (dec_opcode),
        .alu_funct3  (dec_funct3),
        .alu_funct7  (dec_funct7),
        .alu_src_imm (dec_src_imm),
        .rd_is_zero  (dec_rd_zero)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg <= ST_RESET;
            ir_reg    <= '0;
        end else begin
            state_reg <= state_next;
            ir_reg    <= ir_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        ir_next         = ir_reg;
        imem_req_out    = 1'b0;
        dmem_req_out    = 1'b0;
        dmem_we_out     = 1'b0;
        opcode_out      = 7'd0;
        funct3_out      = 3'd0;
        funct7_out      = 7'd0;
        alu_src_imm_out = 1'b0;
        rf_we_out       = 1'b0;
        wb_sel_out      = WB_SEL_ALU;
        pc_en_out       = 1'b0;
        pc_sel_out      = 1'b0;
        trap_out        = 1'b0;

        // ALU fields are held steady for the whole life of the instruction.
        if (state_reg inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB}) begin
            opcode_out      = dec_opcode;
            funct3_out      = dec_funct3;
            funct7_out      = dec_funct7;
            alu_src_imm_out = dec_src_imm;
        end

        case (state_reg)
            ST_RESET: state_next = ST_FETCH;
            ST_FETCH: begin
                imem_req_out = 1'b1;
                if (imem_ack_in) begin
                    ir_next    = instr_in;
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: state_next = dec_legal ? ST_EXEC : ST_TRAP;
            ST_EXEC: begin
                case (dec_class)
                    CLS_LOAD, CLS_STORE: state_next = ST_MEM;
                    CLS_BRANCH: begin
                        pc_en_out  = 1'b1;
                        pc_sel_out = branch_taken_in;
                        state_next = ST_FETCH;
                    end
                    default: state_next = ST_WB;
                endcase
            end
            ST_MEM: begin
                dmem_req_out = 1'b1;
                dmem_we_out  = (dec_class == CLS_STORE);
                if (dmem_ack_in) begin
                    if (dec_class == CLS_STORE) begin
                        pc_en_out  = 1'b1;
                        state_next = ST_FETCH;
                    end else begin
                        state_next = ST_WB;
                    end
                end
            end
            ST_WB: begin
                rf_we_out  = !dec_rd_zero;
                wb_sel_out = (dec_class == CLS_LOAD) ? WB_SEL_MEM : WB_SEL_ALU;
                pc_en_out  = 1'b1;
                state_next = ST_FETCH;
            end
            ST_TRAP: trap_out = 1'b1;
            default: state_next = ST_TRAP;
        endcase
    end

    assign state_out = state_reg;

`ifdef CPU_CTRL_PERF_EN
    logic [PERF_CNT_W-1:0] cycle_cnt_reg, instret_cnt_reg;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cycle_cnt_reg   <= '0;
            instret_cnt_reg <= '0;
        end else if (state_reg != ST_RESET && state_reg != ST_TRAP) begin
            cycle_cnt_reg <= cycle_cnt_reg + 1'b1;
            if (pc_en_out) begin
                instret_cnt_reg <= instret_cnt_reg + 1'b1;
            end
        end
    end

    assign cycle_cnt_out   = cycle_cnt_reg;
    assign instret_cnt_out = instret_cnt_reg;
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm: table of instructions scored through a
// queue, plus hand-written trap and reset-mid-handshake sequences.
module tb_cpu_ctrl_fsm;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        imem_req_out, imem_ack_in;
    logic [31:0] instr_in;
    logic        dmem_req_out, dmem_we_out, dmem_ack_in;
    logic        branch_taken_in;
    logic [6:0]  opcode_out;
    logic [2:0]  funct3_out;
    logic [6:0]  funct7_out;
    logic        alu_src_imm_out, rf_we_out, wb_sel_out;
    logic        pc_en_out, pc_sel_out, trap_out;
    logic [2:0]  state_out;

    cpu_ctrl_fsm #(.XLEN(32)) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .imem_req_out    (imem_req_out),
        .imem_ack_in     (imem_ack_in),
        .instr_in        (instr_in),
        .dmem_req_out    (dmem_req_out),
        .dmem_we_out     (dmem_we_out),
        .dmem_ack_in     (dmem_ack_in),
        .branch_taken_in (branch_taken_in),
        .opcode_out      (opcode_out),
        .funct3_out      (funct3_out),
        .funct7_out      (funct7_out),
        .alu_src_imm_out (alu_src_imm_out),
        .rf_we_out       (rf_we_out),
        .wb_sel_out      (wb_sel_out),
        .pc_en_out       (pc_en_out),
        .pc_sel_out      (pc_sel_out),
        .trap_out        (trap_out),
        .state_out       (state_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] instr;
        int          fd;      // fetch ack delay (cycles)
        int          md;      // data ack delay (cycles)
        logic        br;
        logic [31:0] trace;   // one nibble per cycle, FETCH to last state
        int          cycles;
        int          rf_we;
        logic        wb_sel;
        int          pc_en;
        logic        pc_sel;
        int          dreq;
        logic        dwe;
        logic [17:0] fields;  // {opcode, funct3, funct7, alu_src_imm}
    } vec_t;

    vec_t vecs[13];
    vec_t exp_q[$];
    int   tests  = 0;
    int   failed = 0;

    function automatic logic [17:0] fld(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic imm);
        return {op, f3, f7, imm};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] cur_fields();
        return {opcode_out, funct3_out, funct7_out, alu_src_imm_out};
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        vec_t        e;
        logic [31:0] trace = 0;
        int          cycles = 0, rf_we = 0, pc_en = 0, dreq = 0, bad = 0;
        int          fw = 0, mw = 0;
        logic        wb_sel = 0, pc_sel = 0, dwe = 0, left = 0, done = 0, fref_set = 0;
        logic [17:0] fref = '0, fexec = '0;
        logic [2:0]  st;
        exp_q.push_back(v);
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk_in);
            st = state_out;
            trace = (trace << 4) | {29'd0, st};
            cycles++;
            imem_ack_in = 1'b1;           // stray acks everywhere they must be ignored
            dmem_ack_in = 1'b1;
            instr_in = $urandom;
            branch_taken_in = v.br;
            if (st == 3'd1) begin
                dmem_ack_in = 1'b0;
                if (fw == v.fd) instr_in = v.instr;
                else begin imem_ack_in = 1'b0; fw++; end
                dmem_ack_in = 1'b1;
            end else if (st == 3'd4) begin
                if (mw != v.md) begin dmem_ack_in = 1'b0; mw++; end
            end
            #1;
            if (rf_we_out) rf_we++;
            if (pc_en_out) begin pc_en++; pc_sel = pc_sel_out; end
            if (dmem_req_out) begin dreq++; dwe |= dmem_we_out; end
            if ((st == 3'd1) != imem_req_out) bad++;
            if (trap_out) bad++;
            if (st == 3'd5) wb_sel = wb_sel_out;
            if (st == 3'd3) fexec = cur_fields();
            if (st >= 3'd2 && st <= 3'd5) begin
                if (!fref_set) begin fref = cur_fields(); fref_set = 1; end
                else if (cur_fields() != fref) bad++;
            end
            if (st != 3'd1) left = 1;
            if (st == 3'd0 || st == 3'd6) break;
            @(posedge clk_in);
            #1;
            if (left && state_out == 3'd1) done = 1;
        end
        imem_ack_in = 1'b0;
        dmem_ack_in = 1'b0;
        e = exp_q.pop_front();
        chk($sformatf("v%0d done", idx), {31'd0, done}, 32'd1);
        chk($sformatf("v%0d trace", idx), trace, e.trace);
        chk($sformatf("v%0d cycles", idx), cycles, e.cycles);
        chk($sformatf("v%0d rf_we", idx), rf_we, e.rf_we);
        chk($sformatf("v%0d wb_sel", idx), {31'd0, wb_sel}, {31'd0, e.wb_sel});
        chk($sformatf("v%0d pc_en", idx), pc_en, e.pc_en);
        chk($sformatf("v%0d pc_sel", idx), {31'd0, pc_sel}, {31'd0, e.pc_sel});
        chk($sformatf("v%0d dreq", idx), dreq, e.dreq);
        chk($sformatf("v%0d dwe", idx), {31'd0, dwe}, {31'd0, e.dwe});
        chk($sformatf("v%0d fields", idx), {14'd0, fexec}, {14'd0, e.fields});
        chk($sformatf("v%0d glitches", idx), bad, 0);
        $display("[TB] v%0d instr=%08h trace=%0h cycles=%0d rf_we=%0d pc_en=%0d dreq=%0d",
                 idx, v.instr, trace, cycles, rf_we, pc_en, dreq);
    endtask

    initial begin
        int bad, tcyc, n;
        logic [31:0] trace;

        vecs[0]  = '{32'h00500093, 0, 0, 1'b0, 32'h1235,     4, 1, 1'b0, 1, 1'b0, 0, 1'b0, fld(7'h13, 3'd0, 7'h00, 1'b1)};
        vecs[1]  = '{32'h0040A103, 0, 3, 1'b0, 32'h12344445, 8, 1, 1'b1, 1, 1'b0, 4, 1'b0, fld(7'h13, 3'd0, 7'h00, 1'b1)};
        vecs[2]  = '{32'h0020A423, 0, 0, 1'b0, 32'h1234,     4, 0, 1'b0, 1, 1'b0, 1, 1'b1, fld(7'h13, 3'd0, 7'h00, 1'b1)};
        vecs[3]  = '{32'hFE208CE3, 0, 0, 1'b1, 32'h123,      3, 0, 1'b0, 1, 1'b1, 0, 1'b0, fld(7'h63, 3'd0, 7'h7F, 1'b0)};
        vecs[4]  = '{32'hFE208CE3, 0, 0, 1'b0, 32'h123,      3, 0, 1'b0, 1, 1'b0, 0, 1'b0, fld(7'h63, 3'd0, 7'h7F, 1'b0)};
        vecs[5]  = '{32'h00208033, 0, 0, 1'b0, 32'h1235,     4, 0, 1'b0, 1, 1'b0, 0, 1'b0, fld(7'h33, 3'd0, 7'h00, 1'b0)};
        vecs[6]  = '{32'h402081B3, 0, 0, 1'b0, 32'h1235,     4, 1, 1'b0, 1, 1'b0, 0, 1'b0, fld(7'h33, 3'd0, 7'h20, 1'b0)};
        vecs[7]  = '{32'h4030D293, 0, 0, 1'b0, 32'h1235,     4, 1, 1'b0, 1, 1'b0, 0, 1'b0, fld(7'h13, 3'd5, 7'h20, 1'b1)};
        vecs[8]  = '{32'hFFF08213, 0, 0, 1'b0, 32'h1235,     4, 1, 1'b0, 1, 1'b0, 0, 1'b0, fld(7'h13, 3'd0, 7'h00, 1'b1)};
        vecs[9]  = '{32'hFFF0F313, 0, 0, 1'b0, 32'h1235,     4, 1, 1'b0, 1, 1'b0, 0, 1'b0, fld(7'h13, 3'd7, 7'h00, 1'b1)};
        vecs[10] = '{32'h0040A103, 2, 0, 1'b0, 32'h1112345,  7, 1, 1'b1, 1, 1'b0, 1, 1'b0, fld(7'h13, 3'd0, 7'h00, 1'b1)};
        vecs[11] = '{32'h0020A423, 0, 2, 1'b0, 32'h123444,   6, 0, 1'b0, 1, 1'b0, 3, 1'b1, fld(7'h13, 3'd0, 7'h00, 1'b1)};
        vecs[12] = '{32'h0000A003, 0, 0, 1'b0, 32'h12345,    5, 0, 1'b1, 1, 1'b0, 1, 1'b0, fld(7'h13, 3'd0, 7'h00, 1'b1)};

        rst_n_in = 1'b0;
        imem_ack_in = 1'b0;
        dmem_ack_in = 1'b0;
        instr_in = '0;
        branch_taken_in = 1'b0;

        // Reset state: every output low, state RESET.
        repeat (2) @(negedge clk_in);
        #1;
        chk("reset outputs", {imem_req_out, dmem_req_out, dmem_we_out, opcode_out, funct3_out,
                              funct7_out, alu_src_imm_out, rf_we_out, wb_sel_out, pc_en_out,
                              pc_sel_out, trap_out, state_out}, 32'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        #1;
        chk("reset release state", {29'd0, state_out}, 32'd0);
        @(posedge clk_in);
        #1;
        chk("first fetch", {29'd0, state_out}, 32'd1);
        $display("[TB] reset released, state=%0d", state_out);

        for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

        // Illegal instruction: TRAP is sticky, no reqs or strobes even with stray acks.
        @(negedge clk_in);
        imem_ack_in = 1'b1;
        instr_in = 32'hFFFFFFFF;
        trace = {29'd0, state_out};
        @(negedge clk_in);
        dmem_ack_in = 1'b1;
        instr_in = 32'h00500093;
        trace = (trace << 4) | {29'd0, state_out};
        bad = 0;
        tcyc = 0;
        for (int c = 0; c < 21; c++) begin
            @(negedge clk_in);
            #1;
            if (c == 0) trace = (trace << 4) | {29'd0, state_out};
            if (trap_out && state_out == 3'd6) tcyc++;
            if (imem_req_out || dmem_req_out || rf_we_out || pc_en_out) bad++;
        end
        chk("trap trace", trace, 32'h126);
        chk("trap sticky cycles", tcyc, 21);
        chk("trap quiet", bad, 0);
        $display("[TB] trap: trace=%0h sticky=%0d quiet_violations=%0d", trace, tcyc, bad);

        // Async reset out of TRAP, then while a fetch request is pending.
        rst_n_in = 1'b0;
        #1;
        chk("trap cleared by reset", {28'd0, trap_out, state_out}, 32'd0);
        @(negedge clk_in);
        imem_ack_in = 1'b0;
        dmem_ack_in = 1'b1;
        rst_n_in = 1'b1;
        @(posedge clk_in);
        repeat (2) @(negedge clk_in);
        #1;
        chk("fetch req held", {28'd0, imem_req_out, state_out}, {28'd0, 1'b1, 3'd1});
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("imem_req drops on reset", {28'd0, imem_req_out, state_out}, 32'd0);
        $display("[TB] reset mid-fetch: imem_req=%0d state=%0d", imem_req_out, state_out);

        // Reset while a load waits in MEM: request drops, no write strobe.
        @(negedge clk_in);
        dmem_ack_in = 1'b0;
        rst_n_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        imem_ack_in = 1'b1;
        instr_in = 32'h0040A103;
        @(negedge clk_in);
        imem_ack_in = 1'b0;
        n = 0;
        while (state_out != 3'd4 && n < 10) begin
            @(negedge clk_in);
            n++;
        end
        #1;
        chk("reached MEM", {29'd0, state_out}, 32'd4);
        chk("dmem_req in MEM", {31'd0, dmem_req_out}, 32'd1);
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("dmem_req drops on reset", {29'd0, dmem_req_out, rf_we_out, pc_en_out}, 32'd0);
        $display("[TB] reset mid-mem: dmem_req=%0d rf_we=%0d", dmem_req_out, rf_we_out);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(posedge clk_in);
        run_vec(13, vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
